// File: rtl/part_2_upload_buffer.sv
// Snapshot capture stage: samples {valid, o_data} on each mission-clock rising edge,
// tags it with event index and sequence number, and queues it for export.
module part_2_upload_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int AFULL = 6,
  parameter int SEQW  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [3:0]                 clk_h_i,
  input  logic                       valid,
  input  logic [DW-1:0]              o_data,
  output logic                       out_vld_o,
  input  logic                       out_rdy_i,
  output logic [DW:0]                out_data_o,
  output logic [1:0]                 out_event_o,
  output logic [SEQW-1:0]            out_seq_o,
  output logic [3:0]                 freeze_req_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: an entry transfers on a rising clk_i edge where out_vld_o and
  // out_rdy_i are both high; out_vld_o never depends on out_rdy_i.

  logic [3:0]      clk_h_d;
  logic [3:0]      rise;
  logic [3:0]      pending_q, pending_d;
  logic [DW:0]     pend_data_q [4];
  logic [DW:0]     pend_data_d [4];
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic [3:0]      freeze_q, freeze_d;
  logic            overflow_q, overflow_d;

  logic [DW:0]     mem_data_q  [DEPTH];
  logic [1:0]      mem_event_q [DEPTH];
  logic [SEQW-1:0] mem_seq_q   [DEPTH];

  logic            push, pop;
  logic [1:0]      sel_k;
  logic [3:0]      pend_clr;
  logic [3:0]      pend_held;

  assign rise = clk_h_i & ~clk_h_d;
  assign pop  = (count_q != '0) && out_rdy_i;

  // Lowest pending index wins the single push slot each cycle.
  always_comb begin
    sel_k = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) sel_k = 2'(i);
    end
  end

  assign push     = (pending_q != 4'b0) && ((count_q < CW'(DEPTH)) || pop);
  assign pend_clr = push ? (4'b0001 << sel_k) : 4'b0000;
  // A slot being pushed this cycle is free to take a new capture.
  assign pend_held = pending_q & ~pend_clr;

  always_comb begin
    pending_d  = pend_held;
    overflow_d = overflow_q;
    for (int i = 0; i < 4; i++) begin
      pend_data_d[i] = pend_data_q[i];
      if (rise[i]) begin
        if (pend_held[i]) begin
          overflow_d = 1'b1;
        end else begin
          pending_d[i]   = 1'b1;
          pend_data_d[i] = {valid, o_data};
        end
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      seq_d    = seq_q + SEQW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    freeze_d = 4'b0;
    for (int i = 0; i < 4; i++) begin
      freeze_d[i] = (count_d >= CW'(AFULL)) | pending_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_h_d    <= 4'b0;
      pending_q  <= 4'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      seq_q      <= '0;
      freeze_q   <= 4'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 4; i++) pend_data_q[i] <= '0;
    end else begin
      clk_h_d    <= clk_h_i;
      pending_q  <= pending_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      seq_q      <= seq_d;
      freeze_q   <= freeze_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < 4; i++) pend_data_q[i] <= pend_data_d[i];
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q]  <= pend_data_q[sel_k];
      mem_event_q[wr_ptr_q] <= sel_k;
      mem_seq_q[wr_ptr_q]   <= seq_q;
    end
  end

  assign out_vld_o    = (count_q != '0);
  assign out_data_o   = out_vld_o ? mem_data_q[rd_ptr_q]  : '0;
  assign out_event_o  = out_vld_o ? mem_event_q[rd_ptr_q] : 2'b0;
  assign out_seq_o    = out_vld_o ? mem_seq_q[rd_ptr_q]   : '0;
  assign freeze_req_o = freeze_q;
  assign overflow_o   = overflow_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_part_2_upload_buffer.sv
// Bench for part_2_upload_buffer: directed scenarios with a queue-based scoreboard
// checking every popped entry's payload, event index and sequence number.
module tb_part_2_upload_buffer;

  localparam int DW    = 8;
  localparam int SEQW  = 8;
  localparam int DEPTH = 8;
  localparam int EW    = DW + 1 + 2 + SEQW;

  logic            clk;
  logic            rst_ni;
  logic [3:0]      clk_h;
  logic            valid;
  logic [DW-1:0]   o_data;
  logic            out_vld_o;
  logic            out_rdy_i;
  logic [DW:0]     out_data_o;
  logic [1:0]      out_event_o;
  logic [SEQW-1:0] out_seq_o;
  logic [3:0]      freeze_req_o;
  logic            overflow_o;
  logic [3:0]      count_o;

  part_2_upload_buffer #(.DEPTH(DEPTH), .DW(DW), .AFULL(6), .SEQW(SEQW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clk_h_i      (clk_h),
    .valid        (valid),
    .o_data       (o_data),
    .out_vld_o    (out_vld_o),
    .out_rdy_i    (out_rdy_i),
    .out_data_o   (out_data_o),
    .out_event_o  (out_event_o),
    .out_seq_o    (out_seq_o),
    .freeze_req_o (freeze_req_o),
    .overflow_o   (overflow_o),
    .count_o      (count_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;
  logic [EW-1:0]   exp_q[$];
  logic [SEQW-1:0] seq_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic v, input logic [DW-1:0] d, input logic [1:0] ev);
    exp_q.push_back({v, d, ev, seq_m});
    seq_m = seq_m + 1'b1;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    clk_h     = 4'b0;
    out_rdy_i = 1'b0;
    valid     = 1'b0;
    o_data    = '0;
    exp_q.delete();
    seq_m = '0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic fill(input int n, input int b);
    for (int k = 0; k < n; k++) begin
      valid    = 1'($urandom_range(0, 1));
      o_data   = 8'($urandom_range(0, 255));
      clk_h[b] = 1'b1;
      expect_entry(valid, o_data, 2'(b));
      cyc();
      clk_h[b] = 1'b0;
      cyc();
      check("fill_count", count_o, k + 1);
      check("fill_freeze", freeze_req_o, (k + 1 >= 6) ? 4'hF : 4'h0);
    end
  endtask

  // scoreboard: compare the head whenever a pop will happen at the next edge
  always @(negedge clk) begin
    if (rst_ni && out_vld_o && out_rdy_i) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", out_vld_o, 1'b0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("pop_data",  out_data_o,  e[EW-1:10]);
        check("pop_event", out_event_o, e[9:8]);
        check("pop_seq",   out_seq_o,   e[7:0]);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_ni    = 1'b0;
    clk_h     = 4'b0;
    out_rdy_i = 1'b0;
    valid     = 1'b0;
    o_data    = '0;
    seq_m     = '0;
    #12;
    check("rst_vld",      out_vld_o,    0);
    check("rst_count",    count_o,      0);
    check("rst_freeze",   freeze_req_o, 0);
    check("rst_overflow", overflow_o,   0);
    check("rst_data",     out_data_o,   0);
    check("rst_seq",      out_seq_o,    0);

    // single edge
    do_reset();
    valid = 1'b1; o_data = 8'hA5; clk_h = 4'b0001;
    expect_entry(1'b1, 8'hA5, 2'd0);
    cyc();
    check("single_vld_early", out_vld_o, 0);
    check("single_freeze_pend", freeze_req_o, 4'b0001);
    cyc();
    check("single_vld",    out_vld_o,    1);
    check("single_data",   out_data_o,   9'h1A5);
    check("single_event",  out_event_o,  0);
    check("single_seq",    out_seq_o,    0);
    check("single_count",  count_o,      1);
    check("single_freeze", freeze_req_o, 0);
    clk_h = 4'b0; out_rdy_i = 1'b1;
    cyc();
    check("single_drained", count_o, 0);

    // simultaneous edges
    do_reset();
    out_rdy_i = 1'b1; valid = 1'b1; o_data = 8'h3C; clk_h = 4'b1011;
    expect_entry(1'b1, 8'h3C, 2'd0);
    expect_entry(1'b1, 8'h3C, 2'd1);
    expect_entry(1'b1, 8'h3C, 2'd3);
    cyc();
    check("simul_freeze0", freeze_req_o, 4'b1011);
    check("simul_count0",  count_o, 0);
    cyc();
    check("simul_freeze1", freeze_req_o, 4'b1010);
    check("simul_count1",  count_o, 1);
    cyc();
    check("simul_freeze2", freeze_req_o, 4'b1000);
    check("simul_count2",  count_o, 1);
    cyc();
    check("simul_freeze3", freeze_req_o, 4'b0000);
    check("simul_count3",  count_o, 1);
    cyc();
    check("simul_count4",  count_o, 0);
    clk_h = 4'b0;

    // fill and backpressure
    do_reset();
    fill(8, 2);
    valid = 1'b1; o_data = 8'($urandom_range(0, 255)); clk_h[2] = 1'b1;
    expect_entry(valid, o_data, 2'd2);
    cyc();
    check("bp_freeze_pend", freeze_req_o, 4'hF);
    clk_h[2] = 1'b0;
    cyc();
    check("bp_count_full", count_o, 8);
    check("bp_freeze_full", freeze_req_o, 4'hF);
    out_rdy_i = 1'b1;
    cyc();
    out_rdy_i = 1'b0;
    check("bp_count_pushpop", count_o, 8);
    check("bp_freeze_pushpop", freeze_req_o, 4'hF);
    out_rdy_i = 1'b1;
    repeat (8) cyc();
    check("bp_count_drained", count_o, 0);
    check("bp_vld_drained", out_vld_o, 0);
    check("bp_freeze_drained", freeze_req_o, 0);

    // overflow
    do_reset();
    fill(8, 2);
    valid = 1'b1; o_data = 8'h11; clk_h[1] = 1'b1;
    expect_entry(1'b1, 8'h11, 2'd1);
    cyc();
    check("ovf_before", overflow_o, 0);
    clk_h[1] = 1'b0;
    cyc();
    o_data = 8'h77; clk_h[1] = 1'b1;
    cyc();
    check("ovf_set", overflow_o, 1);
    check("ovf_count", count_o, 8);
    clk_h = 4'b0; out_rdy_i = 1'b1;
    repeat (9) cyc();
    check("ovf_drained", count_o, 0);
    check("ovf_sticky", overflow_o, 1);

    // sequence wrap
    do_reset();
    out_rdy_i = 1'b1;
    for (int i = 0; i < 257; i++) begin
      valid    = 1'($urandom_range(0, 1));
      o_data   = 8'($urandom_range(0, 255));
      clk_h[0] = 1'b1;
      expect_entry(valid, o_data, 2'd0);
      cyc();
      check("wrap_count_le1a", (count_o <= 4'd1), 1);
      clk_h[0] = 1'b0;
      cyc();
      check("wrap_count_le1b", (count_o <= 4'd1), 1);
    end
    repeat (3) cyc();
    check("wrap_drained", exp_q.size(), 0);

    // async reset mid-burst
    do_reset();
    fill(5, 0);
    valid = 1'b1; o_data = 8'($urandom_range(0, 255)); clk_h = 4'b0110;
    cyc();
    check("arst_pre_count", count_o, 5);
    check("arst_pre_freeze", freeze_req_o, 4'b0110);
    rst_ni = 1'b0;
    #1;
    check("arst_vld",      out_vld_o,    0);
    check("arst_count",    count_o,      0);
    check("arst_freeze",   freeze_req_o, 0);
    check("arst_overflow", overflow_o,   0);
    exp_q.delete();
    seq_m = '0;
    clk_h = 4'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();
    cyc();
    check("arst_idle_count", count_o, 0);
    check("arst_idle_vld", out_vld_o, 0);
    valid = 1'b0; o_data = 8'h5A; clk_h[3] = 1'b1;
    expect_entry(1'b0, 8'h5A, 2'd3);
    cyc();
    cyc();
    check("arst_new_vld",   out_vld_o,   1);
    check("arst_new_event", out_event_o, 3);
    check("arst_new_count", count_o,     1);
    out_rdy_i = 1'b1;
    cyc();
    check("arst_new_drained", count_o, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
